// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding-select, load-use stall and branch-flush control
// for a five-stage in-order pipeline. A shadow of the EX, MEM and WB
// register fields is tracked internally, so forwarding selects depend on
// registered state only.
//
// Optional feature: define HAZARD_CTRL_STALL_CNT_EN to add the saturating
// 16-bit stall-cycle counter on port stall_cnt_o.
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        ex_branch_taken_i,
    output logic [1:0]  fwd_a_o,
    output logic [1:0]  fwd_b_o,
    output logic        stall_o,
    output logic        flush_o
`ifdef HAZARD_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_o
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    stage_t r_ex, r_mem, r_wb;
    stage_t w_ex_next;
    logic   w_flush;
    logic   w_load_use;
    logic   w_stall;

    // The newest producer (MEM) wins over the older one (WB); x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input stage_t     mem,
                                           input stage_t     wb);
        if (mem.valid && mem.regwrite && (mem.rd != 5'd0) && (mem.rd == rs))
            return FWD_MEM;
        else if (wb.valid && wb.regwrite && (wb.rd != 5'd0) && (wb.rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // Hazard detection and the value EX will take on the next edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_ex_next  = BUBBLE;
        w_flush    = ex_branch_taken_i;
        w_load_use = r_ex.valid && r_ex.memread && (r_ex.rd != 5'd0) && id_valid_i &&
                     ((r_ex.rd == id_rs1_i) || (r_ex.rd == id_rs2_i));
        // A taken branch squashes the ID instruction, so it also cancels a load-use stall.
        w_stall    = w_load_use && !w_flush;
        if (id_valid_i && !w_stall && !w_flush) begin
            w_ex_next.valid    = 1'b1;
            w_ex_next.rs1      = id_rs1_i;
            w_ex_next.rs2      = id_rs2_i;
            w_ex_next.rd       = id_rd_i;
            w_ex_next.regwrite = id_regwrite_i;
            w_ex_next.memread  = id_memread_i;
        end
    end

    // Shadow pipeline: advances every cycle; the EX occupant always moves on to MEM.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: the shadow stages are cleared by reset because stale valid bits would raise false stalls and forwards.
        if (!rst_n_i) begin
            r_ex  <= BUBBLE;
            r_mem <= BUBBLE;
            r_wb  <= BUBBLE;
        end else begin
            // NOTE: non-blocking assignments let all three stages shift off the same pre-edge values.
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign fwd_a_o = fwd_sel(r_ex.rs1, r_mem, r_wb);
    assign fwd_b_o = fwd_sel(r_ex.rs2, r_mem, r_wb);
    assign stall_o = w_stall;
    assign flush_o = w_flush;

`ifdef HAZARD_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_stall_cnt <= 16'd0;
        else if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    // The later stages carry the full entry for uniformity; only some fields are consumed.
    logic w_unused;
    assign w_unused = ^{r_mem.rs1, r_mem.rs2, r_mem.memread,
                        r_wb.rs1, r_wb.rs2, r_wb.memread};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized instruction stream,
// checked every cycle against a history-based reference model.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_regwrite_i, id_memread_i;
    logic        ex_branch_taken_i;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic        stall_o, flush_o;
    logic [15:0] dut_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .id_valid_i        (id_valid_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .id_rd_i           (id_rd_i),
        .id_regwrite_i     (id_regwrite_i),
        .id_memread_i      (id_memread_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o),
        .stall_o           (stall_o),
        .flush_o           (flush_o)
`ifdef HAZARD_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o       (dut_cnt)
`endif
    );

`ifndef HAZARD_CTRL_STALL_CNT_EN
    assign dut_cnt = 16'd0;
`endif

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    // hist[0] is the instruction issued most recently (now in EX),
    // hist[1] the one before it, hist[2] the one before that.
    typedef struct packed {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr;
    } ins_t;

    ins_t hist[$];
    int   m_cnt;
    bit   m_last_stall;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        for (int age = 1; age <= 2; age++)
            if (hist[age].v && hist[age].rw && hist[age].rd != 5'd0 && hist[age].rd == rs)
                return (age == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall();
        if (!rst_n_i || ex_branch_taken_i || !id_valid_i) return 1'b0;
        if (!(hist[0].v && hist[0].mr && hist[0].rd != 5'd0)) return 1'b0;
        return (hist[0].rd == id_rs1_i) || (hist[0].rd == id_rs2_i);
    endfunction

    function automatic void m_clear();
        hist = '{ins_t'(0), ins_t'(0), ins_t'(0)};
        m_cnt = 0;
        m_last_stall = 1'b0;
    endfunction

    function automatic void m_edge();
        ins_t n;
        bit   s;
        if (!rst_n_i) begin
            m_clear();
            return;
        end
        s = m_stall();
        n = '0;
        if (id_valid_i && !s && !ex_branch_taken_i)
            n = '{1'b1, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i};
        hist.push_front(n);
        void'(hist.pop_back());
        if (s && m_cnt < 65535) m_cnt++;
        m_last_stall = s;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("fwd_a", {14'd0, fwd_a_o}, {14'd0, m_fwd(hist[0].rs1)});
        check("fwd_b", {14'd0, fwd_b_o}, {14'd0, m_fwd(hist[0].rs2)});
        check("stall", {15'd0, stall_o}, {15'd0, m_stall()});
        check("flush", {15'd0, flush_o}, {15'd0, ex_branch_taken_i});
`ifdef HAZARD_CTRL_STALL_CNT_EN
        check("stall_cnt", dut_cnt, 16'(m_cnt));
`endif
    endtask

    task automatic drv(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit br);
        id_valid_i        = v;
        id_rs1_i          = 5'(rs1);
        id_rs2_i          = 5'(rs2);
        id_rd_i           = 5'(rd);
        id_regwrite_i     = rw;
        id_memread_i      = mr;
        ex_branch_taken_i = br;
        #1;
    endtask

    task automatic set_rst(input bit v);
        rst_n_i = v;
        if (!v) m_clear();
        #1;
    endtask

    // Compare on the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk_i);
        compare_all();
        @(posedge clk_i);
        m_edge();
        #1;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_clear();
        rst_n_i = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 1);
        check("reset_flush_follows", {15'd0, flush_o}, 16'd1);
        check("reset_stall", {15'd0, stall_o}, 16'd0);
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        cycle();
        set_rst(1);

        // Load-use: lw x7; add rs1=x7 -> one stall, bubble, then WB forward.
        drv(1, 1, 2, 7, 1, 1, 0); cycle();
        drv(1, 7, 3, 8, 1, 0, 0);
        check("lu_stall_on", {15'd0, stall_o}, 16'd1);
        check("lu_cnt_before", dut_cnt, 16'd0);
        cycle();
        drv(1, 7, 3, 8, 1, 0, 0);
        check("lu_stall_off", {15'd0, stall_o}, 16'd0);
`ifdef HAZARD_CTRL_STALL_CNT_EN
        check("lu_cnt_after", dut_cnt, 16'd1);
`endif
        cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("lu_fwd_a_wb", {14'd0, fwd_a_o}, 16'd1);
        cycle(); nop(); nop();

        // add x5; add rs1=x5 -> MEM forward, no stall.
        drv(1, 1, 2, 5, 1, 0, 0); cycle();
        drv(1, 5, 4, 6, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("mem_fwd_a", {14'd0, fwd_a_o}, 16'd2);
        check("mem_fwd_nostall", {15'd0, stall_o}, 16'd0);
        cycle(); nop(); nop();

        // add x5; nop; sub rs2=x5 -> WB forward on operand B.
        drv(1, 1, 2, 5, 1, 0, 0); cycle();
        nop();
        drv(1, 3, 5, 9, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("wb_fwd_b", {14'd0, fwd_b_o}, 16'd1);
        check("wb_fwd_a_none", {14'd0, fwd_a_o}, 16'd0);
        cycle();

        // add x5; add x5; consumer -> newest (MEM) wins on both operands.
        drv(1, 1, 2, 5, 1, 0, 0); cycle();
        drv(1, 1, 2, 5, 1, 0, 0); cycle();
        drv(1, 5, 5, 9, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("prio_fwd_a", {14'd0, fwd_a_o}, 16'd2);
        check("prio_fwd_b", {14'd0, fwd_b_o}, 16'd2);
        cycle(); nop(); nop();

        // add x0; consumer rs1=x0 -> never forwarded.
        drv(1, 1, 2, 0, 1, 0, 0); cycle();
        drv(1, 0, 0, 4, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("x0_fwd_a", {14'd0, fwd_a_o}, 16'd0);
        check("x0_fwd_b", {14'd0, fwd_b_o}, 16'd0);
        cycle(); nop(); nop();

        // lw x7 in EX, dependent in ID, branch taken -> flush wins.
        drv(1, 1, 2, 7, 1, 1, 0); cycle();
        drv(1, 7, 0, 8, 1, 0, 1);
        check("flush_wins_flush", {15'd0, flush_o}, 16'd1);
        check("flush_wins_stall", {15'd0, stall_o}, 16'd0);
        cycle();
        drv(1, 7, 0, 8, 1, 0, 0);
        check("flush_bubble_nostall", {15'd0, stall_o}, 16'd0);
        cycle(); nop(); nop();

        // Reset asserted mid-stall, held three cycles, then forwarding resumes.
        drv(1, 1, 2, 7, 1, 1, 0); cycle();
        drv(1, 7, 0, 8, 1, 0, 0);
        check("rst_pre_stall", {15'd0, stall_o}, 16'd1);
        set_rst(0);
        check("rst_stall_drop", {15'd0, stall_o}, 16'd0);
        check("rst_fwd_a", {14'd0, fwd_a_o}, 16'd0);
        check("rst_fwd_b", {14'd0, fwd_b_o}, 16'd0);
        check("rst_cnt", dut_cnt, 16'd0);
        cycle(); cycle(); cycle();
        set_rst(1);
        drv(1, 1, 2, 5, 1, 0, 0); cycle();
        drv(1, 5, 4, 6, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_fwd_a", {14'd0, fwd_a_o}, 16'd2);
        cycle();

        // Randomized stream; ID is held while the model says a stall occurred.
        for (int i = 0; i < 3000; i++) begin
            if (!rst_n_i) begin
                if ($urandom_range(0, 2) == 0) set_rst(1);
            end else if ($urandom_range(0, 399) == 0) begin
                set_rst(0);
            end
            if (m_last_stall && rst_n_i) begin
                drv(id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, 0);
            end else begin
                bit rw;
                rw = ($urandom_range(0, 3) != 0);
                drv($urandom_range(0, 7) != 0,
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    rw, rw && ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 9) == 0);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports as below; one clock; reset asynchronous, active-low:
- clk_i  in  1  rising-edge clock
- rst_n_i  in  1  asynchronous active-low reset
- id_valid_i  in  1  ID-stage instruction valid
- id_rs1_i  in  5  ID source register 1
- id_rs2_i  in  5  ID source register 2
- id_rd_i  in  5  ID destination register
- id_regwrite_i  in  1  ID instruction writes rd
- id_memread_i  in  1  ID instruction is a load
- ex_branch_taken_i  in  1  branch/jump resolved taken in EX
- fwd_a_o  out  2  select for operand-A 3:1 mux: 00 regfile, 01 WB result, 10 MEM ALU result
- fwd_b_o  out  2  same encoding for operand-B mux
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  clear IF/ID
- stall_cnt_o  out  16  stall-cycle count (only with REQ-019 macro)

Function
REQ-002 SHALL keep an internal shadow of three stages (EX, MEM, WB), each entry holding valid, rs1, rs2, rd, regwrite, memread; entries advance EX->MEM->WB every cycle.
REQ-003 SHALL load the EX entry from the id_* inputs each cycle, except that it SHALL load a bubble (valid=0, regwrite=0, memread=0) when stall_o or flush_o is 1, or id_valid_i is 0.
REQ-004 fwd_a_o SHALL be 10 when MEM.valid, MEM.regwrite, MEM.rd!=0, MEM.rd==EX.rs1; else 01 when same condition holds for WB; else 00.
REQ-005 fwd_b_o SHALL follow REQ-004 using EX.rs2.
REQ-006 MEM match SHALL take priority over WB match (newest value wins).
REQ-007 x0 (rd==0) SHALL never be forwarded; selector value 11 SHALL never be driven.
REQ-008 fwd_a_o/fwd_b_o SHALL be combinational functions of shadow-register state only (no input-to-output path).
REQ-009 stall_o SHALL be 1 when EX.valid, EX.memread, EX.rd!=0, id_valid_i, and EX.rd equals id_rs1_i or id_rs2_i (load-use); else 0.
REQ-010 A load-use stall SHALL last exactly one cycle; the following cycle the load is in MEM and forwarding occurs via WB on the next advance (load data reaches the mux from WB).
REQ-011 flush_o SHALL equal ex_branch_taken_i combinationally.
REQ-012 When flush_o and the stall condition coincide, flush SHALL win: stall_o=0, EX loads bubble.
REQ-013 The instruction in EX during a taken branch SHALL still advance to MEM normally.
REQ-014 Back-to-back loads with dependent consumers SHALL each produce one independent stall cycle.

Reset
REQ-015 On rst_n_i=0, all shadow entries SHALL clear to bubbles immediately, independent of clk_i.
REQ-016 During reset: fwd_a_o=00, fwd_b_o=00, stall_o=0, stall_cnt_o=0; flush_o follows ex_branch_taken_i.
REQ-017 Reset asserted mid-stall SHALL drop stall_o to 0 in the same cycle.
REQ-018 First clock edge after release SHALL load EX per REQ-003.

Configuration
REQ-019 With HAZARD_CTRL_STALL_CNT_EN defined, stall_cnt_o SHALL exist and increment by 1 every cycle stall_o=1, saturating at 16'hFFFF, cleared only by reset.
REQ-020 Without HAZARD_CTRL_STALL_CNT_EN, port stall_cnt_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-021 add x5 (rd=5) then add rs1=x5 next cycle -> consumer in EX sees fwd_a_o=10, stall_o=0.
REQ-022 add x5; nop; sub rs2=x5 -> sub in EX sees fwd_b_o=01; with add x5 in MEM and another add x5 in WB -> fwd=10.
REQ-023 lw x7; add rs1=x7 -> stall_o=1 for exactly one cycle, EX bubble, then consumer sees fwd_a_o=01; stall_cnt_o 0->1 when macro defined.
REQ-024 add x0 then consumer rs1=x0 -> fwd_a_o=00.
REQ-025 lw x7 in EX, ID rs1=x7, ex_branch_taken_i=1 same cycle -> flush_o=1, stall_o=0, EX bubble next cycle.
REQ-026 rst_n_i low for 3 cycles mid-stall -> stall_o=0 immediately, fwd_*_o=00, stall_cnt_o=0; normal forwarding resumes after release.
